// File: rtl/pll_reset_ctrl.sv
// rtl/pll_reset_ctrl.sv - reset/lock sequencer for one PLL wrapper instance
// Optional saturating loss-of-lock counter: define PLL_RESET_CTRL_LOSS_COUNT_EN.
module pll_reset_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_FILTER  = 8,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwrdwn_req,
  input  logic       restart,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       pll_pwrdwn,
  output logic       ready,
  output logic       fail,
  output logic       lost_lock,
  output logic [3:0] retry_cnt,
  output logic [2:0] state,
  output logic [7:0] loss_cnt
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TOW = $clog2(LOCK_TIMEOUT);
  localparam int FLW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;

  localparam logic [RCW-1:0] RST_LAST   = RCW'(RST_CYCLES - 1);
  localparam logic [TOW-1:0] TMO_LAST   = TOW'(LOCK_TIMEOUT - 1);
  localparam logic [FLW-1:0] FILT_LAST  = FLW'(LOCK_FILTER - 1);
  localparam logic [3:0]     RETRY_MAX  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PWRDN  = 3'd0,
    ST_RESET  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_FILTER = 3'd3,
    ST_READY  = 3'd4,
    ST_FAIL   = 3'd5
  } state_e;

  state_e         state_q;
  logic           sync1_q, locked_s_q;
  logic           pll_rst_q, pwrdwn_q, ready_q, fail_q, lost_lock_q;
  logic [3:0]     retry_q;
  logic [RCW-1:0] rst_cnt_q;
  logic [TOW-1:0] tmo_q;
  logic [FLW-1:0] filt_q;

  // pll_locked is asynchronous to clk; only the second flop is ever used.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RESET;
      pll_rst_q   <= 1'b1;
      pwrdwn_q    <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lost_lock_q <= 1'b0;
      retry_q     <= '0;
      rst_cnt_q   <= '0;
      tmo_q       <= '0;
      filt_q      <= '0;
    end else begin
      lost_lock_q <= 1'b0;
      if (pwrdwn_req) begin
        state_q   <= ST_PWRDN;
        pwrdwn_q  <= 1'b1;
        pll_rst_q <= 1'b1;
        ready_q   <= 1'b0;
      end else if (state_q == ST_PWRDN || restart) begin
        state_q   <= ST_RESET;
        pwrdwn_q  <= 1'b0;
        pll_rst_q <= 1'b1;
        ready_q   <= 1'b0;
        fail_q    <= 1'b0;
        retry_q   <= '0;
        rst_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_RESET: begin
            if (rst_cnt_q == RST_LAST) begin
              state_q   <= ST_WAIT;
              pll_rst_q <= 1'b0;
              tmo_q     <= '0;
            end else begin
              rst_cnt_q <= rst_cnt_q + 1'b1;
            end
          end
          ST_WAIT, ST_FILTER: begin
            tmo_q <= tmo_q + 1'b1;
            // Timeout outranks any lock event seen in the same cycle.
            if (tmo_q == TMO_LAST) begin
              pll_rst_q <= 1'b1;
              if (retry_q < RETRY_MAX) begin
                state_q   <= ST_RESET;
                retry_q   <= retry_q + 1'b1;
                rst_cnt_q <= '0;
              end else begin
                state_q <= ST_FAIL;
                fail_q  <= 1'b1;
              end
            end else if (state_q == ST_WAIT) begin
              if (locked_s_q) begin
                state_q <= ST_FILTER;
                filt_q  <= '0;
              end
            end else if (!locked_s_q) begin
              state_q <= ST_WAIT;
            end else if (filt_q == FILT_LAST) begin
              state_q <= ST_READY;
              ready_q <= 1'b1;
              retry_q <= '0;
            end else begin
              filt_q <= filt_q + 1'b1;
            end
          end
          ST_READY: begin
            if (!locked_s_q) begin
              state_q     <= ST_RESET;
              ready_q     <= 1'b0;
              lost_lock_q <= 1'b1;
              pll_rst_q   <= 1'b1;
              rst_cnt_q   <= '0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign pll_rst    = pll_rst_q;
  assign pll_pwrdwn = pwrdwn_q;
  assign ready      = ready_q;
  assign fail       = fail_q;
  assign lost_lock  = lost_lock_q;
  assign retry_cnt  = retry_q;
  assign state      = state_q;

`ifdef PLL_RESET_CTRL_LOSS_COUNT_EN
  logic [7:0] loss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else if (lost_lock_q && loss_cnt_q != 8'hFF) begin
      loss_cnt_q <= loss_cnt_q + 1'b1;
    end
  end

  assign loss_cnt = loss_cnt_q;
`else
  assign loss_cnt = 8'd0;
`endif

endmodule
